// File: rtl/mixer_param_bank.sv
// mixer_param_bank
// Register bank for a synth voice mixer: per-oscillator parameters (osc bank),
// common parameters (master volume, 16-byte patch name) and N_MAT modulation
// matrices. The host reads and writes through a one-hot selected bank. A dump
// engine streams the whole patch out over a valid/ready handshake.
//
// Ports
//   clk, reset_data_N        clock, async active-low reset
//   adr, bank_sel            register address / one-hot bank (bit0 osc, bit1 com, bit2+k matrix k)
//   wr_en, rd_en, data_in    host strobes and write data
//   data_out, rd_valid       read data, valid one cycle after rd_en
//   dump_start/ready         dump request and sink handshake
//   dump_byte/bank/adr/valid current dump item
//   dump_busy, dump_done     dump in progress / one-cycle completion pulse
//   osc_*, m_vol, patch_name, mat_buf  live register contents
//   mat_buf byte ((k*16+o)*V_OSC+i) holds matrix k, row o, column i.
module mixer_param_bank #(
    parameter int V_OSC = 4,
    parameter int N_MAT = 2
) (
    input  logic                          clk,
    input  logic                          reset_data_N,
    input  logic [6:0]                    adr,
    input  logic [N_MAT+1:0]              bank_sel,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic signed [7:0]             data_in,
    output logic signed [7:0]             data_out,
    output logic                          rd_valid,
    input  logic                          dump_start,
    output logic [7:0]                    dump_byte,
    output logic [2:0]                    dump_bank,
    output logic [6:0]                    dump_adr,
    output logic                          dump_valid,
    input  logic                          dump_ready,
    output logic                          dump_busy,
    output logic                          dump_done,
    output logic [8*V_OSC-1:0]            osc_lvl,
    output logic [8*V_OSC-1:0]            osc_mod_out,
    output logic [8*V_OSC-1:0]            osc_feedb_out,
    output logic [8*V_OSC-1:0]            osc_pan,
    output logic [8*V_OSC-1:0]            osc_mod_in,
    output logic [8*V_OSC-1:0]            osc_feedb_in,
    output logic [7:0]                    m_vol,
    output logic [8*16-1:0]               patch_name,
    output logic [8*N_MAT*16*V_OSC-1:0]   mat_buf
);

    localparam int                 SELW      = N_MAT + 2;
    localparam logic [SELW-1:0]    SEL_ZERO  = {SELW{1'b0}};
    localparam logic [SELW-1:0]    SEL_ONE   = {{(SELW-1){1'b0}}, 1'b1};
    localparam logic [6:0]         MAT_LAST  = 7'((V_OSC << 4) - 1);
    localparam logic [2:0]         LAST_BANK = 3'(N_MAT + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_OSC, ST_COM, ST_MAT, ST_DONE} dump_state_t;

    // Storage: osc_r[o][p] with p = lvl, mod_out, feedb_out, pan, mod_in, feedb_in
    logic [7:0]  osc_r  [0:V_OSC-1][0:5];
    logic [7:0]  m_vol_r;
    logic [7:0]  name_r [0:15];
    logic [7:0]  mat_r  [0:N_MAT-1][0:15][0:V_OSC-1];

    logic        sel_ok_s;
    logic [2:0]  bank_num_s;
    logic [7:0]  host_val_s;
    logic [2:0]  load_bank_s;
    logic [6:0]  load_adr_s;
    logic        load_last_s;
    logic [7:0]  load_byte_s;

    dump_state_t state_r;
    logic [7:0]  dump_byte_r;
    logic [2:0]  dump_bank_r;
    logic [6:0]  dump_adr_r;
    logic        dump_valid_r;
    logic        dump_busy_r;
    logic        dump_done_r;

    // Osc-bank offset to parameter index; 15 means reserved/unmapped.
    function automatic logic [3:0] osc_param(input logic [3:0] off);
        logic [3:0] p;
        case (off)
            4'd2:    p = 4'd0;
            4'd3:    p = 4'd1;
            4'd4:    p = 4'd2;
            4'd7:    p = 4'd3;
            4'd10:   p = 4'd4;
            4'd11:   p = 4'd5;
            default: p = 4'd15;
        endcase
        return p;
    endfunction

    // Live value of register (bank number, address); unmapped reads as zero.
    function automatic logic [7:0] reg_value(input logic [2:0] bnk, input logic [6:0] a);
        logic [7:0] v;
        v = 8'h00;
        if (bnk == 3'd0) begin
            for (int o = 0; o < V_OSC; o++)
                for (int p = 0; p < 6; p++)
                    if (a[6:4] == 3'(o) && osc_param(a[3:0]) == 4'(p)) v = osc_r[o][p];
        end else if (bnk == 3'd1) begin
            if (a == 7'd1)              v = m_vol_r;
            else if (a[6:4] == 3'd1)    v = name_r[a[3:0]];
            else                        v = 8'h00;
        end else begin
            for (int k = 0; k < N_MAT; k++)
                for (int i = 0; i < V_OSC; i++)
                    if (bnk == 3'(k + 2) && a[6:4] == 3'(i)) v = mat_r[k][a[3:0]][i];
        end
        return v;
    endfunction

    // Dump order successor of (bank, adr): returns {last, next_bank, next_adr}.
    // Osc items walk the six mapped offsets plus reserved 12..15 of each oscillator.
    function automatic logic [10:0] next_item(input logic [2:0] bnk, input logic [6:0] a);
        logic [2:0] nb;
        logic [6:0] na;
        logic       last;
        nb   = bnk;
        na   = a + 7'd1;
        last = 1'b0;
        if (bnk == 3'd0) begin
            if (a[3:0] == 4'd15) begin
                if (a[6:4] == 3'(V_OSC - 1)) begin
                    nb = 3'd1;
                    na = 7'd1;
                end else begin
                    na = {a[6:4] + 3'd1, 4'd2};
                end
            end else if (a[3:0] == 4'd4) begin
                na = {a[6:4], 4'd7};
            end else if (a[3:0] == 4'd7) begin
                na = {a[6:4], 4'd10};
            end else begin
                na = a + 7'd1;
            end
        end else if (bnk == 3'd1) begin
            if (a == 7'd1)       na = 7'd16;
            else if (a == 7'd31) begin
                nb = 3'd2;
                na = 7'd0;
            end else             na = a + 7'd1;
        end else begin
            if (a == MAT_LAST) begin
                if (bnk == LAST_BANK) last = 1'b1;
                else begin
                    nb = bnk + 3'd1;
                    na = 7'd0;
                end
            end else begin
                na = a + 7'd1;
            end
        end
        return {last, nb, na};
    endfunction

    function automatic dump_state_t bank_state(input logic [2:0] bnk);
        dump_state_t s;
        if (bnk == 3'd0)      s = ST_OSC;
        else if (bnk == 3'd1) s = ST_COM;
        else                  s = ST_MAT;
        return s;
    endfunction

    // Host select decode: one-hot check and bank number.
    always_comb begin
        sel_ok_s   = (bank_sel != SEL_ZERO) && ((bank_sel & (bank_sel - SEL_ONE)) == SEL_ZERO);
        bank_num_s = 3'd0;
        for (int b = 0; b < SELW; b++) begin
            if (bank_sel[b]) bank_num_s = 3'(b);
            else             bank_num_s = bank_num_s;
        end
        host_val_s = sel_ok_s ? reg_value(bank_num_s, adr) : 8'h00;
    end

    // Item the dump engine will load next: the first item from IDLE, else the successor.
    always_comb begin
        if (state_r == ST_IDLE) begin
            load_last_s = 1'b0;
            load_bank_s = 3'd0;
            load_adr_s  = 7'h02;
        end else begin
            {load_last_s, load_bank_s, load_adr_s} = next_item(dump_bank_r, dump_adr_r);
        end
        load_byte_s = reg_value(load_bank_s, load_adr_s);
    end

    // Register file writes; non-one-hot selects and unmapped addresses are dropped.
    always_ff @(posedge clk or negedge reset_data_N) begin
        if (!reset_data_N) begin
            for (int o = 0; o < V_OSC; o++)
                for (int p = 0; p < 6; p++)
                    osc_r[o][p] <= (((p == 0) && (o < 2)) || (p == 3)) ? 8'h40 : 8'h00;
            m_vol_r <= 8'h40;
            for (int j = 0; j < 16; j++) name_r[j] <= 8'h20;
            for (int k = 0; k < N_MAT; k++)
                for (int o = 0; o < 16; o++)
                    for (int i = 0; i < V_OSC; i++)
                        mat_r[k][o][i] <= 8'h00;
        end else if (wr_en && sel_ok_s) begin
            for (int o = 0; o < V_OSC; o++)
                for (int p = 0; p < 6; p++)
                    if (bank_sel[0] && adr[6:4] == 3'(o) && osc_param(adr[3:0]) == 4'(p))
                        osc_r[o][p] <= data_in;
            if (bank_sel[1] && adr == 7'd1) m_vol_r <= data_in;
            for (int j = 0; j < 16; j++)
                if (bank_sel[1] && adr == 7'(16 + j)) name_r[j] <= data_in;
            for (int k = 0; k < N_MAT; k++)
                for (int o = 0; o < 16; o++)
                    for (int i = 0; i < V_OSC; i++)
                        if (bank_sel[k + 2] && adr == 7'((i << 4) + o)) mat_r[k][o][i] <= data_in;
        end else begin
            m_vol_r <= m_vol_r;
        end
    end

    // Host read port: one cycle latency, values sampled before any same-cycle write.
    always_ff @(posedge clk or negedge reset_data_N) begin
        if (!reset_data_N) begin
            rd_valid <= 1'b0;
            data_out <= 8'sh00;
        end else if (rd_en) begin
            rd_valid <= 1'b1;
            data_out <= host_val_s;
        end else begin
            rd_valid <= 1'b0;
            data_out <= data_out;
        end
    end

    // Dump FSM: each item is captured from the live registers when entered and
    // held until its handshake, so later host writes cannot disturb it.
    always_ff @(posedge clk or negedge reset_data_N) begin
        if (!reset_data_N) begin
            state_r      <= ST_IDLE;
            dump_byte_r  <= 8'h00;
            dump_bank_r  <= 3'd0;
            dump_adr_r   <= 7'd0;
            dump_valid_r <= 1'b0;
            dump_busy_r  <= 1'b0;
            dump_done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    dump_done_r <= 1'b0;
                    if (dump_start) begin
                        state_r      <= ST_OSC;
                        dump_busy_r  <= 1'b1;
                        dump_valid_r <= 1'b1;
                        dump_bank_r  <= load_bank_s;
                        dump_adr_r   <= load_adr_s;
                        dump_byte_r  <= load_byte_s;
                    end else begin
                        dump_busy_r  <= 1'b0;
                        dump_valid_r <= 1'b0;
                    end
                end
                ST_OSC, ST_COM, ST_MAT: begin
                    if (dump_valid_r && dump_ready) begin
                        if (load_last_s) begin
                            state_r      <= ST_DONE;
                            dump_valid_r <= 1'b0;
                            dump_done_r  <= 1'b1;
                        end else begin
                            state_r      <= bank_state(load_bank_s);
                            dump_bank_r  <= load_bank_s;
                            dump_adr_r   <= load_adr_s;
                            dump_byte_r  <= load_byte_s;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    dump_done_r <= 1'b0;
                    dump_busy_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    dump_valid_r <= 1'b0;
                    dump_busy_r  <= 1'b0;
                    dump_done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign dump_byte  = dump_byte_r;
    assign dump_bank  = dump_bank_r;
    assign dump_adr   = dump_adr_r;
    assign dump_valid = dump_valid_r;
    assign dump_busy  = dump_busy_r;
    assign dump_done  = dump_done_r;
    assign m_vol      = m_vol_r;

    for (genvar o = 0; o < V_OSC; o++) begin : g_osc
        assign osc_lvl[8*o +: 8]       = osc_r[o][0];
        assign osc_mod_out[8*o +: 8]   = osc_r[o][1];
        assign osc_feedb_out[8*o +: 8] = osc_r[o][2];
        assign osc_pan[8*o +: 8]       = osc_r[o][3];
        assign osc_mod_in[8*o +: 8]    = osc_r[o][4];
        assign osc_feedb_in[8*o +: 8]  = osc_r[o][5];
    end

    for (genvar j = 0; j < 16; j++) begin : g_name
        assign patch_name[8*j +: 8] = name_r[j];
    end

    for (genvar k = 0; k < N_MAT; k++) begin : g_mk
        for (genvar o = 0; o < 16; o++) begin : g_mo
            for (genvar i = 0; i < V_OSC; i++) begin : g_mi
                assign mat_buf[8*((k*16 + o)*V_OSC + i) +: 8] = mat_r[k][o][i];
            end
        end
    end

endmodule

// File: tb/tb_mixer_param_bank.sv
// Self-checking bench for mixer_param_bank at default parameters. The reference
// model is a flat byte memory indexed by a "slot" number computed from the
// register map arithmetic; the dump order is built as a list of (bank, adr).
module tb_mixer_param_bank;
    localparam int V     = 4;
    localparam int N     = 2;
    localparam int NB    = N + 2;
    localparam int TOTAL = 10*V + 17 + N*16*V;
    localparam int VOL   = 6*V;
    localparam int NAME0 = 6*V + 1;
    localparam int MAT0  = 6*V + 17;
    localparam int MEMN  = MAT0 + N*16*V;

    logic                  clk = 1'b0;
    logic                  reset_data_N = 1'b1;
    logic [6:0]            adr = 7'd0;
    logic [NB-1:0]         bank_sel = '0;
    logic                  wr_en = 1'b0, rd_en = 1'b0, dump_start = 1'b0, dump_ready = 1'b0;
    logic signed [7:0]     data_in = 8'sh00;
    logic signed [7:0]     data_out;
    logic                  rd_valid, dump_valid, dump_busy, dump_done;
    logic [7:0]            dump_byte, m_vol;
    logic [2:0]            dump_bank;
    logic [6:0]            dump_adr;
    logic [8*V-1:0]        osc_lvl, osc_mod_out, osc_feedb_out, osc_pan, osc_mod_in, osc_feedb_in;
    logic [127:0]          patch_name;
    logic [8*N*16*V-1:0]   mat_buf;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mem [0:MEMN-1];
    int         exp_bank [$];
    int         exp_adr  [$];

    mixer_param_bank #(.V_OSC(V), .N_MAT(N)) dut (
        .clk(clk), .reset_data_N(reset_data_N), .adr(adr), .bank_sel(bank_sel),
        .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(data_out),
        .rd_valid(rd_valid), .dump_start(dump_start), .dump_byte(dump_byte),
        .dump_bank(dump_bank), .dump_adr(dump_adr), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_busy(dump_busy), .dump_done(dump_done),
        .osc_lvl(osc_lvl), .osc_mod_out(osc_mod_out), .osc_feedb_out(osc_feedb_out),
        .osc_pan(osc_pan), .osc_mod_in(osc_mod_in), .osc_feedb_in(osc_feedb_in),
        .m_vol(m_vol), .patch_name(patch_name), .mat_buf(mat_buf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int param_of_offset(input int off);
        case (off)
            2: return 0;   3: return 1;   4: return 2;
            7: return 3;  10: return 4;  11: return 5;
            default: return -1;
        endcase
    endfunction

    // Model slot for (select, address); -1 when nothing is addressed.
    function automatic int slot(input logic [NB-1:0] sel, input int a);
        int r;
        r = -1;
        if ($countones(sel) == 1) begin
            if (sel[0]) begin
                if (a/16 < V && param_of_offset(a%16) >= 0) r = (a/16)*6 + param_of_offset(a%16);
            end else if (sel[1]) begin
                if (a == 1) r = VOL;
                else if (a >= 16 && a <= 31) r = NAME0 + a - 16;
            end else begin
                for (int k = 0; k < N; k++)
                    if (sel[k+2] && a/16 < V) r = MAT0 + k*16*V + (a%16)*V + a/16;
            end
        end
        return r;
    endfunction

    task automatic reset_model();
        for (int s = 0; s < MEMN; s++) mem[s] = 8'h00;
        for (int o = 0; o < V; o++) begin
            if (o < 2) mem[o*6 + 0] = 8'h40;
            mem[o*6 + 3] = 8'h40;
        end
        mem[VOL] = 8'h40;
        for (int j = 0; j < 16; j++) mem[NAME0 + j] = 8'h20;
    endtask

    task automatic build_dump_list();
        exp_bank.delete();
        exp_adr.delete();
        for (int o = 0; o < V; o++)
            for (int off = 0; off < 16; off++)
                if (off >= 12 || param_of_offset(off) >= 0) begin
                    exp_bank.push_back(0); exp_adr.push_back(o*16 + off);
                end
        exp_bank.push_back(1); exp_adr.push_back(1);
        for (int a = 16; a < 32; a++) begin exp_bank.push_back(1); exp_adr.push_back(a); end
        for (int k = 0; k < N; k++)
            for (int a = 0; a < 16*V; a++) begin exp_bank.push_back(2 + k); exp_adr.push_back(a); end
    endtask

    task automatic apply_reset();
        rd_en = 1'b0; wr_en = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
        reset_data_N = 1'b0;
        tick(); tick();
        reset_model();
        reset_data_N = 1'b1;
        tick();
    endtask

    task automatic check_buses(input string tag);
        logic [8*V-1:0]      eo [0:5];
        logic [8*V-1:0]      go [0:5];
        logic [127:0]        en;
        logic [8*N*16*V-1:0] em;
        go[0] = osc_lvl; go[1] = osc_mod_out; go[2] = osc_feedb_out;
        go[3] = osc_pan; go[4] = osc_mod_in;  go[5] = osc_feedb_in;
        for (int p = 0; p < 6; p++)
            for (int o = 0; o < V; o++) eo[p][8*o +: 8] = mem[o*6 + p];
        for (int j = 0; j < 16; j++) en[8*j +: 8] = mem[NAME0 + j];
        for (int j = 0; j < N*16*V; j++) em[8*j +: 8] = mem[MAT0 + j];
        for (int p = 0; p < 6; p++) begin
            n_tests++;
            if (go[p] !== eo[p]) begin
                n_fail++;
                $display("FAIL %s osc_param%0d: got %h expected %h", tag, p, go[p], eo[p]);
            end
        end
        n_tests++;
        if (m_vol !== mem[VOL]) begin
            n_fail++; $display("FAIL %s m_vol: got %h expected %h", tag, m_vol, mem[VOL]);
        end
        n_tests++;
        if (patch_name !== en) begin
            n_fail++; $display("FAIL %s patch_name: got %h expected %h", tag, patch_name, en);
        end
        n_tests++;
        if (mat_buf !== em) begin
            n_fail++;
            for (int j = 0; j < N*16*V; j++)
                if (mat_buf[8*j +: 8] !== em[8*j +: 8]) begin
                    $display("FAIL %s mat_buf byte %0d: got %h expected %h", tag, j, mat_buf[8*j +: 8], em[8*j +: 8]);
                    break;
                end
        end
    endtask

    task automatic host_read(input logic [NB-1:0] sel, input int a, input logic [7:0] expv, input string tag);
        bank_sel = sel; adr = 7'(a); rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_tests++;
        if (rd_valid !== 1'b1 || data_out !== expv) begin
            n_fail++;
            $display("FAIL %s: got valid=%b data=%h expected valid=1 data=%h", tag, rd_valid, data_out, expv);
        end
        tick();
        n_tests++;
        if (rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s rd_valid drop: got %b expected 0", tag, rd_valid);
        end
    endtask

    task automatic test_reset();
        reset_data_N = 1'b0;
        #3;
        n_tests++;
        if (rd_valid !== 1'b0 || dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0 || data_out !== 8'sh00) begin
            n_fail++;
            $display("FAIL reset_flags: got rdv=%b dv=%b busy=%b done=%b dout=%h expected all 0",
                     rd_valid, dump_valid, dump_busy, dump_done, data_out);
        end
        reset_model();
        check_buses("reset");
        reset_data_N = 1'b1;
        tick();
        host_read(4'b0001, 8'h12, 8'h40, "read_osc_0x12");
        host_read(4'b0010, 1, 8'h40, "read_com_1");
    endtask

    task automatic test_matrix_write();
        bank_sel = 4'b1000; adr = 7'h23; data_in = 8'sh55; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        mem[slot(4'b1000, 8'h23)] = 8'h55;
        host_read(4'b1000, 8'h23, 8'h55, "mat1_readback");
        n_tests++;
        if (mat_buf[((16 + 3)*V + 2)*8 +: 8] !== 8'h55 || mat_buf[8*16*V-1:0] !== '0) begin
            n_fail++;
            $display("FAIL mat1_bus: got m[1][3][2]=%h bank0=%h expected 55 and 0",
                     mat_buf[((16 + 3)*V + 2)*8 +: 8], mat_buf[8*16*V-1:0] != '0);
        end
    endtask

    task automatic test_rw_same_cycle();
        bank_sel = 4'b0001; adr = 7'h07; data_in = 8'sh7F; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        n_tests++;
        if (rd_valid !== 1'b1 || data_out !== 8'sh40) begin
            n_fail++; $display("FAIL rw_same_cycle: got %b/%h expected 1/40", rd_valid, data_out);
        end
        mem[slot(4'b0001, 7)] = 8'h7F;
        host_read(4'b0001, 7, 8'h7F, "rw_followup");
    endtask

    task automatic test_random_rw();
        logic [NB-1:0] sel;
        logic [7:0]    d, expv;
        int            a, op, s, bad;
        bad = 0;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) != 0) sel = NB'(1) << $urandom_range(0, NB-1);
            else                           sel = NB'($urandom);
            a  = $urandom_range(0, 127);
            d  = 8'($urandom);
            op = $urandom_range(0, 2);
            s  = slot(sel, a);
            expv = (s < 0) ? 8'h00 : mem[s];
            bank_sel = sel; adr = 7'(a); data_in = d;
            rd_en = (op != 1); wr_en = (op != 0);
            tick();
            rd_en = 1'b0; wr_en = 1'b0;
            n_tests++;
            if ((op != 1 && (rd_valid !== 1'b1 || data_out !== expv)) || (op == 1 && rd_valid !== 1'b0)) begin
                n_fail++;
                $display("FAIL random_rw it=%0d sel=%b adr=%h op=%0d: got %b/%h expected %b/%h",
                         it, sel, a, op, rd_valid, data_out, op != 1, expv);
            end
            if (op != 0 && s >= 0) mem[s] = d;
            if (it % 100 == 99) check_buses("random");
        end
    endtask

    // mode 0: ready held high; mode 1: ready 1-of-3 with a host write to a
    // presented item; mode 2: stop after 60 handshakes (caller resets).
    task automatic run_dump(input int mode, output int handshakes);
        int idx, cyc, done_cnt, valid_cyc, seen, bad, s;
        logic [7:0] snap;
        logic       rdy;
        bit         wrote;
        idx = 0; cyc = 0; done_cnt = 0; valid_cyc = 0; seen = -1; bad = 0; wrote = 0; snap = 8'h00;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        n_tests++;
        if (dump_busy !== 1'b1 || dump_valid !== 1'b1) begin
            n_fail++; $display("FAIL dump_start m%0d: got busy=%b valid=%b expected 1/1", mode, dump_busy, dump_valid);
        end
        while (cyc < 3000 && !(idx == TOTAL && done_cnt > 0)) begin
            wr_en = 1'b0;
            if (mode == 2 && idx == 60) break;
            if (dump_done === 1'b1) begin
                done_cnt++;
                if (dump_busy !== 1'b1 || dump_valid !== 1'b0) bad++;
            end
            if (dump_valid === 1'b1) begin
                valid_cyc++;
                if (idx >= TOTAL) bad++;
                else begin
                    if (idx != seen) begin
                        seen = idx;
                        s = slot(NB'(1) << exp_bank[idx], exp_adr[idx]);
                        snap = (s < 0) ? 8'h00 : mem[s];
                        if (mode == 0 && (idx == 0 || idx == 40)) begin
                            n_tests++;
                            if (dump_bank !== ((idx == 0) ? 3'd0 : 3'd1) || dump_adr !== ((idx == 0) ? 7'h02 : 7'h01) || dump_byte !== 8'h40) begin
                                n_fail++;
                                $display("FAIL dump_item%0d: got bank=%0d adr=%h byte=%h expected %0d/%h/40",
                                         idx + 1, dump_bank, dump_adr, dump_byte, (idx == 0) ? 0 : 1, (idx == 0) ? 2 : 1);
                            end
                        end
                    end
                    if (dump_bank !== 3'(exp_bank[idx]) || dump_adr !== 7'(exp_adr[idx]) || dump_byte !== snap) begin
                        bad++;
                        if (bad <= 4)
                            $display("FAIL dump_seq m%0d item=%0d: got %0d/%h/%h expected %0d/%h/%h",
                                     mode, idx, dump_bank, dump_adr, dump_byte, exp_bank[idx], exp_adr[idx], snap);
                    end
                end
            end else if (idx < TOTAL && mode != 1) begin
                bad++;
            end
            rdy = (mode == 1) ? (cyc % 3 == 2) : 1'b1;
            dump_ready = rdy;
            if (mode == 1 && dump_valid === 1'b1 && idx == 3 && !rdy && !wrote) begin
                bank_sel = 4'b0001; adr = 7'(exp_adr[idx]); data_in = ~snap; wr_en = 1'b1;
                mem[slot(4'b0001, exp_adr[idx])] = ~snap;
                wrote = 1;
            end
            if (dump_valid === 1'b1 && rdy) idx++;
            tick();
            cyc++;
        end
        dump_ready = 1'b0;
        wr_en = 1'b0;
        handshakes = idx;
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL dump_items m%0d: got %0d bad cycles expected 0", mode, bad);
        end
        if (mode != 2) begin
            n_tests++;
            if (idx != TOTAL || done_cnt != 1) begin
                n_fail++; $display("FAIL dump_count m%0d: got %0d bytes %0d done expected %0d/1", mode, idx, done_cnt, TOTAL);
            end
            n_tests++;
            if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_done !== 1'b0) begin
                n_fail++; $display("FAIL dump_end m%0d: got busy=%b valid=%b done=%b expected 0", mode, dump_busy, dump_valid, dump_done);
            end
        end
        if (mode == 0) begin
            n_tests++;
            if (valid_cyc != TOTAL || cyc != TOTAL + 1) begin
                n_fail++; $display("FAIL dump_rate: got %0d valid in %0d cycles expected %0d in %0d", valid_cyc, cyc, TOTAL, TOTAL + 1);
            end
        end
        if (mode == 1) begin
            n_tests++;
            if (!wrote || valid_cyc <= TOTAL) begin
                n_fail++; $display("FAIL dump_stall: got wrote=%0d valid_cycles=%0d expected 1 and >%0d", wrote, valid_cyc, TOTAL);
            end
        end
    endtask

    task automatic test_dump_ready_high();
        int h;
        apply_reset();
        run_dump(0, h);
    endtask

    task automatic test_dump_stall();
        int h;
        run_dump(1, h);
        check_buses("after_stall_dump");
    endtask

    task automatic test_dump_reset();
        int h;
        apply_reset();
        run_dump(2, h);
        reset_data_N = 1'b0;
        #1;
        n_tests++;
        if (h != 60 || dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_done !== 1'b0) begin
            n_fail++;
            $display("FAIL dump_reset: got hs=%0d busy=%b valid=%b done=%b expected 60/0/0/0", h, dump_busy, dump_valid, dump_done);
        end
        tick();
        reset_model();
        reset_data_N = 1'b1;
        tick();
        run_dump(0, h);
    endtask

    initial begin
        build_dump_list();
        test_reset();
        test_matrix_write();
        test_rw_same_cycle();
        test_random_rw();
        test_dump_ready_high();
        test_dump_stall();
        test_dump_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
